vga_timing_gen: RTL

//   640x480@60 VGA raster timing stage that sits directly upstream of the frame/score pixel generator.
//   It produces the pixel coordinates and a once-per-pixel enable strobe that the generator consumes.
//   It registers the generator's returned 24-bit colour into the DAC outputs with hsync, vsync and blank,
//   so all video pins leave the block mutually aligned.

---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle between the VGA timing stage and the pixel generator / DAC pins.
interface vga_timing_gen_if;
  logic [23:0] color_in;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        vga_ready;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  // Timing generator side: drives coordinates, strobes and video pins.
  modport master (
    input  color_in,
    output pixel_x, pixel_y, vga_ready, frame_start,
    output hsync, vsync, blank_n, vga_r, vga_g, vga_b
  );

  // Pixel generator / consumer side.
  modport slave (
    output color_in,
    input  pixel_x, pixel_y, vga_ready, frame_start,
    input  hsync, vsync, blank_n, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, and a registered video
// output stage so sync, blank and colour leave the block on the same edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,   // 1..16 clk cycles per pixel
  parameter int SYNC_POL = 0    // active level of hsync/vsync
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Thresholds pre-sized to the counter width so every compare is 10 bits.
  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_L   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_L   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_L   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_L   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = !SYNC_ON;

  logic [3:0]  div_q, div_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic [23:0] rgb_q, rgb_d;

  logic ready;
  logic active;
  logic in_hsync;
  logic in_vsync;

  // With one clk per pixel every clk is a pixel boundary, so the strobe is
  // tied high rather than decoded from a counter that never moves.
  generate
    if (CLK_DIV == 1) begin : g_div1
      assign ready = 1'b1;
    end else begin : g_divn
      assign ready = (div_q == DIV_LAST);
    end
  endgenerate

  // Decodes of the current (pre-advance) position feeding the video registers.
  assign active   = (h_q < H_ACT_L) && (v_q < V_ACT_L);
  assign in_hsync = (h_q >= H_SS_L) && (h_q < H_SE_L);
  assign in_vsync = (v_q >= V_SS_L) && (v_q < V_SE_L);

  // Next-state: divider always runs; counters and video regs move only on ready.
  always_comb begin
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    rgb_d   = rgb_q;
    if (ready) begin
      div_d = '0;
      if (h_q == H_LAST_L) begin
        h_d = '0;
        if (v_q == V_LAST_L) begin
          v_d = '0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
      blank_d = active;
      rgb_d   = active ? vga.color_in : 24'd0;
      hs_d    = in_hsync ? SYNC_ON : SYNC_OFF;
      vs_d    = in_vsync ? SYNC_ON : SYNC_OFF;
    end else begin
      div_d = div_q + 4'd1;
    end
  end

  // State register with synchronous reset to the idle raster origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= SYNC_OFF;
      vs_q    <= SYNC_OFF;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.pixel_x     = {6'd0, h_q};
  assign vga.pixel_y     = {6'd0, v_q};
  assign vga.vga_ready   = ready;
  assign vga.frame_start = ready && (h_q == H_LAST_L) && (v_q == V_LAST_L);
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.blank_n     = blank_q;
  assign vga.vga_r       = rgb_q[23:16];
  assign vga.vga_g       = rgb_q[15:8];
  assign vga.vga_b       = rgb_q[7:0];

endmodule
